score_arbiter: RTL

//  Sequences the per-hit score datapath for the four finger lanes. Each lane

---
 rtl/score_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/score_arbiter.sv
// Score datapath sequencer: one pending event slot per finger lane, round-robin
// grant of one score/combo update per cycle, and the IDLE/PLAY/DRAIN/DONE phase FSM.
module score_arbiter #(
    parameter int LANES    = 4,
    parameter int PTS_HIT  = 1,
    parameter int PTS_MISS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [LANES-1:0] hit_valid,
    input  logic [LANES-1:0] hit_res,
    output logic [7:0]       score,
    output logic [7:0]       combo,
    output logic [7:0]       max_combo,
    output logic             playing,
    output logic             done,
    output logic             upd_valid,
    output logic [1:0]       upd_lane,
    output logic             overflow,
    output logic [1:0]       dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } phaseT;

    phaseT            state;
    phaseT            nextState;
    logic [LANES-1:0] pending;
    logic [LANES-1:0] pendingNext;
    logic [LANES-1:0] lastRes;
    logic [LANES-1:0] lastResNext;
    logic [1:0]       rrPtr;
    logic             grantValid;
    logic [1:0]       grantLane;
    logic [1:0]       probe;
    logic             captureEn;
    logic             arbEnable;
    logic             ovfSet;
    logic [8:0]       hitSum;
    logic [8:0]       missDiff;
    logic [7:0]       scoreHit;
    logic [7:0]       scoreMiss;
    logic [7:0]       comboHit;

    // Handshake: hit_valid[i] is a one-cycle strobe with no back-pressure; an event
    // is accepted at the edge it is sampled in PLAY unless lane i already holds an
    // ungranted event, in which case it is dropped and overflow latches.

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        captureEn = 1'b0;
        arbEnable = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = PLAY;
            end
            PLAY: begin
                captureEn = 1'b1;
                arbEnable = 1'b1;
                if (start)     nextState = PLAY;
                else if (stop) nextState = DRAIN;
            end
            DRAIN: begin
                arbEnable = 1'b1;
                if (start)               nextState = PLAY;
                else if (pending == '0)  nextState = DONE;
            end
            DONE: begin
                if (start) nextState = PLAY;
            end
            default: nextState = IDLE;
        endcase
    end

    // Walk from the farthest offset down so the nearest pending lane to rrPtr wins.
    always_comb begin
        grantValid = 1'b0;
        grantLane  = '0;
        probe      = '0;
        if (arbEnable) begin
            for (int k = LANES - 1; k >= 0; k--) begin
                probe = rrPtr + 2'(k);
                if (pending[probe]) begin
                    grantValid = 1'b1;
                    grantLane  = probe;
                end
            end
        end
    end

    // A lane being granted this cycle frees its slot, so a fresh event may refill it.
    always_comb begin
        pendingNext = pending;
        lastResNext = lastRes;
        ovfSet      = 1'b0;
        if (grantValid) pendingNext[grantLane] = 1'b0;
        if (captureEn) begin
            for (int i = 0; i < LANES; i++) begin
                if (hit_valid[i]) begin
                    if (pendingNext[i]) begin
                        ovfSet = 1'b1;
                    end else begin
                        pendingNext[i] = 1'b1;
                        lastResNext[i] = hit_res[i];
                    end
                end
            end
        end
    end

    assign hitSum    = {1'b0, score} + 9'(PTS_HIT);
    assign missDiff  = {1'b0, score} - 9'(PTS_MISS);
    assign scoreHit  = hitSum[8] ? 8'hFF : hitSum[7:0];
    assign scoreMiss = missDiff[8] ? 8'h00 : missDiff[7:0];
    assign comboHit  = (combo == 8'hFF) ? 8'hFF : combo + 8'd1;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            pending   <= '0;
            lastRes   <= '0;
            rrPtr     <= '0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
            overflow  <= 1'b0;
            upd_valid <= 1'b0;
            upd_lane  <= '0;
        end else begin
            pending   <= pendingNext;
            lastRes   <= lastResNext;
            upd_valid <= grantValid;
            if (ovfSet) overflow <= 1'b1;
            if (grantValid) begin
                rrPtr    <= grantLane + 2'd1;
                upd_lane <= grantLane;
                if (lastRes[grantLane]) begin
                    score <= scoreHit;
                    combo <= comboHit;
                    if (comboHit > max_combo) max_combo <= comboHit;
                end else begin
                    score <= scoreMiss;
                    combo <= '0;
                end
            end
        end
    end

    assign playing  = (state == PLAY);
    assign done     = (state == DONE);
    assign dbgState = state;

endmodule
